// File: rtl/bconv_sched_pkg.sv
// Shared types and helpers for the binary 3x3 conv frame/row/channel sequencer.
// State encoding, default configuration widths and width helper functions.
package bconv_sched_pkg;

   typedef enum logic [3:0] {
      ST_IDLE     = 4'd0,
      ST_VSYNC    = 4'd1,
      ST_ROW_WAIT = 4'd2,
      ST_HSYNC    = 4'd3,
      ST_WLOAD    = 4'd4,
      ST_WSETTLE  = 4'd5,
      ST_REUSE    = 4'd6,
      ST_STREAM   = 4'd7,
      ST_GAP      = 4'd8,
      ST_RGAP     = 4'd9,
      ST_DONE     = 4'd10
   } state_e;

   localparam int DEF_WIDTH_D = 2;
   localparam int DEF_LEN     = 3;
   localparam int DEF_CHANNEL = 64;
   localparam int DEF_SIZE    = 56;
   localparam int DEF_GAP     = 4;
   localparam int DEF_ROW_GAP = 64;

   localparam int CW  = $clog2(DEF_CHANNEL);
   localparam int SW  = $clog2(DEF_SIZE);
   localparam int WAW = $clog2(DEF_CHANNEL * DEF_CHANNEL / 2);

   function automatic int lb_aw(input int channel, input int size);
      return $clog2(channel) + $clog2(size);
   endfunction

   function automatic int w_aw(input int channel);
      return $clog2(channel * channel / 2);
   endfunction

   function automatic int max4(input int a, input int b, input int c, input int d);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return m;
   endfunction

endpackage

// File: rtl/bconv_sched_if.sv
// Bus between the conv sequencer and its line buffer, weight ROM, conv core and frame control.
interface bconv_sched_if
   import bconv_sched_pkg::*;
#(
   parameter int WIDTH_D = DEF_WIDTH_D,
   parameter int LEN     = DEF_LEN,
   parameter int CHANNEL = DEF_CHANNEL,
   parameter int SIZE    = DEF_SIZE
) ();

   localparam int DW      = WIDTH_D * LEN;
   localparam int WIDTH_W = WIDTH_D * LEN * LEN;
   localparam int LBW     = lb_aw(CHANNEL, SIZE);
   localparam int WAW_I   = w_aw(CHANNEL);

   logic                   i_start;
   logic                   i_ready;
   logic                   o_busy;
   logic                   o_done;
   logic                   o_lb_rden;
   logic [LBW-1:0]         o_lb_addr;
   logic [DW-1:0]          i_lb_data;
   logic                   o_w_rden;
   logic [WAW_I-1:0]       o_w_addr;
   logic [2*WIDTH_W-1:0]   i_w_data;
   logic                   o_vsync;
   logic                   o_hsync;
   logic                   o_reuse;
   logic                   o_valid;
   logic [DW-1:0]          o_tdata;
   logic                   o_weight_vld;
   logic [2*WIDTH_W-1:0]   o_weight;

   modport master (
      input  i_start, i_ready, i_lb_data, i_w_data,
      output o_busy, o_done, o_lb_rden, o_lb_addr, o_w_rden, o_w_addr,
             o_vsync, o_hsync, o_reuse, o_valid, o_tdata, o_weight_vld, o_weight
   );

   modport slave (
      output i_start, i_ready, i_lb_data, i_w_data,
      input  o_busy, o_done, o_lb_rden, o_lb_addr, o_w_rden, o_w_addr,
             o_vsync, o_hsync, o_reuse, o_valid, o_tdata, o_weight_vld, o_weight
   );

endinterface

// File: rtl/bconv_sched_cnt.sv
// Clearable up-counter used for in-state cycles, channel passes and rows.
module bconv_sched_cnt #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         en,
   output logic [W-1:0] cnt
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      if (clr) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = cnt_q + W'(1'b1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/bconv_sched.sv
// Frame/row/channel sequencer for the binary 3x3 conv stage: emits sync strobes,
// weight loads and column streams, and realigns latency-1 memory data onto the conv inputs.
module bconv_sched
   import bconv_sched_pkg::*;
#(
   parameter int WIDTH_D = DEF_WIDTH_D,
   parameter int LEN     = DEF_LEN,
   parameter int CHANNEL = DEF_CHANNEL,
   parameter int SIZE    = DEF_SIZE,
   parameter int GAP     = DEF_GAP,
   parameter int ROW_GAP = DEF_ROW_GAP
) (
   input  logic          i_sclk,
   input  logic          i_rst,
   bconv_sched_if.master bus
);

   localparam int CW_L    = $clog2(CHANNEL);
   localparam int SW_L    = $clog2(SIZE);
   localparam int WAW_L   = w_aw(CHANNEL);
   localparam int LBW     = CW_L + SW_L;
   localparam int DW      = WIDTH_D * LEN;
   localparam int WIDTH_W = WIDTH_D * LEN * LEN;
   localparam int HALF    = CHANNEL / 2;
   localparam int CYC_MAX = max4(HALF, SIZE, GAP, ROW_GAP);
   localparam int CNTW    = $clog2(CYC_MAX + 1);

   localparam logic [CNTW-1:0] TC_WLOAD  = CNTW'(HALF - 1);
   localparam logic [CNTW-1:0] TC_STREAM = CNTW'(SIZE - 1);
   localparam logic [CNTW-1:0] TC_GAP    = CNTW'(GAP - 1);
   localparam logic [CNTW-1:0] TC_RGAP   = CNTW'(ROW_GAP - 1);
   localparam logic [CW_L-1:0] PASS_LAST = CW_L'(CHANNEL - 1);
   localparam logic [SW_L-1:0] ROW_LAST  = SW_L'(SIZE - 1);

   state_e              state_q, state_d;
   logic [CNTW-1:0]     cyc;
   logic [CW_L-1:0]     pass;
   logic [SW_L-1:0]     row;
   logic                cyc_last;
   logic                pass_adv;
   logic                row_adv;
   logic                frame_go;

   logic                vsync_q, vsync_d;
   logic                hsync_q, hsync_d;
   logic                reuse_q, reuse_d;
   logic                done_q, done_d;
   logic                busy_q, busy_d;
   logic                lb_rden_q, lb_rden_d;
   logic [LBW-1:0]      lb_addr_q, lb_addr_d;
   logic                w_rden_q, w_rden_d;
   logic [WAW_L-1:0]    w_addr_q, w_addr_d;
   // Memory data arrives one cycle after the strobe; these mark that cycle.
   logic                lb_dv_q, lb_dv_d;
   logic                w_dv_q, w_dv_d;
   logic                valid_q, valid_d;
   logic [DW-1:0]       tdata_q, tdata_d;
   logic                wvld_q, wvld_d;
   logic [2*WIDTH_W-1:0] weight_q, weight_d;

   bconv_sched_cnt #(.W(CNTW)) u_cyc (
      .clk (i_sclk),
      .rst (i_rst),
      .clr (state_d != state_q),
      .en  (1'b1),
      .cnt (cyc)
   );

   bconv_sched_cnt #(.W(CW_L)) u_pass (
      .clk (i_sclk),
      .rst (i_rst),
      .clr (row_adv | frame_go),
      .en  (pass_adv),
      .cnt (pass)
   );

   bconv_sched_cnt #(.W(SW_L)) u_row (
      .clk (i_sclk),
      .rst (i_rst),
      .clr (frame_go),
      .en  (row_adv),
      .cnt (row)
   );

   always_ff @(posedge i_sclk) begin
      if (i_rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      case (state_q)
         ST_WLOAD:  cyc_last = (cyc == TC_WLOAD);
         ST_STREAM: cyc_last = (cyc == TC_STREAM);
         ST_GAP:    cyc_last = (cyc == TC_GAP);
         ST_RGAP:   cyc_last = (cyc == TC_RGAP);
         default:   cyc_last = 1'b0;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      pass_adv = 1'b0;
      row_adv  = 1'b0;
      frame_go = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus.i_start) begin
               state_d  = ST_VSYNC;
               frame_go = 1'b1;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_VSYNC: state_d = ST_ROW_WAIT;
         ST_ROW_WAIT: begin
            if (bus.i_ready) begin
               state_d = ST_HSYNC;
            end else begin
               state_d = ST_ROW_WAIT;
            end
         end
         ST_HSYNC:   state_d = ST_WLOAD;
         ST_WLOAD: begin
            if (cyc_last) begin
               state_d = ST_WSETTLE;
            end else begin
               state_d = ST_WLOAD;
            end
         end
         ST_WSETTLE: state_d = ST_REUSE;
         ST_REUSE:   state_d = ST_STREAM;
         ST_STREAM: begin
            if (cyc_last) begin
               state_d = ST_GAP;
            end else begin
               state_d = ST_STREAM;
            end
         end
         ST_GAP: begin
            if (!cyc_last) begin
               state_d = ST_GAP;
            end else if (pass == PASS_LAST) begin
               state_d = ST_RGAP;
            end else begin
               state_d  = ST_WLOAD;
               pass_adv = 1'b1;
            end
         end
         ST_RGAP: begin
            if (!cyc_last) begin
               state_d = ST_RGAP;
            end else if (row == ROW_LAST) begin
               state_d = ST_DONE;
            end else begin
               state_d = ST_ROW_WAIT;
               row_adv = 1'b1;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Strobes are registered copies of the current state, so each lags its state by one cycle.
   always_comb begin
      vsync_d   = (state_q == ST_VSYNC);
      hsync_d   = (state_q == ST_HSYNC);
      reuse_d   = (state_q == ST_REUSE);
      done_d    = (state_q == ST_DONE);
      busy_d    = (state_d != ST_IDLE);
      lb_rden_d = (state_q == ST_STREAM);
      w_rden_d  = (state_q == ST_WLOAD);
      if (lb_rden_d) begin
         lb_addr_d = {pass, cyc[SW_L-1:0]};
      end else begin
         lb_addr_d = '0;
      end
      if (w_rden_d) begin
         w_addr_d = WAW_L'(pass) * WAW_L'(HALF) + WAW_L'(cyc);
      end else begin
         w_addr_d = '0;
      end
      lb_dv_d = lb_rden_q;
      w_dv_d  = w_rden_q;
      valid_d = lb_dv_q;
      wvld_d  = w_dv_q;
      if (lb_dv_q) begin
         tdata_d = bus.i_lb_data;
      end else begin
         tdata_d = '0;
      end
      if (w_dv_q) begin
         weight_d = bus.i_w_data;
      end else begin
         weight_d = '0;
      end
   end

   always_ff @(posedge i_sclk) begin
      if (i_rst) begin
         vsync_q   <= 1'b0;
         hsync_q   <= 1'b0;
         reuse_q   <= 1'b0;
         done_q    <= 1'b0;
         busy_q    <= 1'b0;
         lb_rden_q <= 1'b0;
         lb_addr_q <= '0;
         w_rden_q  <= 1'b0;
         w_addr_q  <= '0;
         lb_dv_q   <= 1'b0;
         w_dv_q    <= 1'b0;
         valid_q   <= 1'b0;
         tdata_q   <= '0;
         wvld_q    <= 1'b0;
         weight_q  <= '0;
      end else begin
         vsync_q   <= vsync_d;
         hsync_q   <= hsync_d;
         reuse_q   <= reuse_d;
         done_q    <= done_d;
         busy_q    <= busy_d;
         lb_rden_q <= lb_rden_d;
         lb_addr_q <= lb_addr_d;
         w_rden_q  <= w_rden_d;
         w_addr_q  <= w_addr_d;
         lb_dv_q   <= lb_dv_d;
         w_dv_q    <= w_dv_d;
         valid_q   <= valid_d;
         tdata_q   <= tdata_d;
         wvld_q    <= wvld_d;
         weight_q  <= weight_d;
      end
   end

   assign bus.o_vsync      = vsync_q;
   assign bus.o_hsync      = hsync_q;
   assign bus.o_reuse      = reuse_q;
   assign bus.o_done       = done_q;
   assign bus.o_busy       = busy_q;
   assign bus.o_lb_rden    = lb_rden_q;
   assign bus.o_lb_addr    = lb_addr_q;
   assign bus.o_w_rden     = w_rden_q;
   assign bus.o_w_addr     = w_addr_q;
   assign bus.o_valid      = valid_q;
   assign bus.o_tdata      = tdata_q;
   assign bus.o_weight_vld = wvld_q;
   assign bus.o_weight     = weight_q;

endmodule

// File: tb/tb_bconv_sched.sv
// Directed bench for bconv_sched with CHANNEL=4, SIZE=8, GAP=4, ROW_GAP=6 and
// address-derived line-buffer / weight-ROM models.
module tb_bconv_sched;

   localparam int WIDTH_D  = 2;
   localparam int LEN      = 3;
   localparam int CHANNEL  = 4;
   localparam int SIZE     = 8;
   localparam int GAP      = 4;
   localparam int ROW_GAP  = 6;
   localparam int HALF     = CHANNEL / 2;
   localparam int ROW_CYC  = 72;    // row wait 1 + hsync 1 + 4 passes x 16 + row gap 6
   localparam int DONE_OFS = 578;   // vsync 1 + 8 rows x 72, then done strobe one cycle later

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   bconv_sched_if #(.WIDTH_D(WIDTH_D), .LEN(LEN), .CHANNEL(CHANNEL), .SIZE(SIZE)) bus ();

   bconv_sched #(
      .WIDTH_D(WIDTH_D), .LEN(LEN), .CHANNEL(CHANNEL),
      .SIZE(SIZE), .GAP(GAP), .ROW_GAP(ROW_GAP)
   ) dut (
      .i_sclk (clk),
      .i_rst  (rst),
      .bus    (bus)
   );

   function automatic logic [5:0] lb_model(input logic [4:0] a);
      return ({1'b0, a} * 6'd13) ^ 6'h15;
   endfunction

   function automatic logic [35:0] w_model(input logic [2:0] a);
      return {a, ~a, 6'h2D ^ {3'b000, a}, 24'hC3A596 ^ {8{a}}};
   endfunction

   // k-th column read of a frame: channel = pass index, column within the pass
   function automatic logic [4:0] lb_a(input int k);
      logic [1:0] ch;
      logic [2:0] col;
      ch  = 2'((k / SIZE) % CHANNEL);
      col = 3'(k % SIZE);
      return {ch, col};
   endfunction

   // Latency-1 memories; junk on idle cycles so ungated data would show.
   always @(posedge clk) begin
      if (bus.o_lb_rden) bus.i_lb_data <= lb_model(bus.o_lb_addr);
      else               bus.i_lb_data <= 6'($urandom);
      if (bus.o_w_rden)  bus.i_w_data  <= w_model(bus.o_w_addr);
      else               bus.i_w_data  <= {4'($urandom), 32'($urandom)};
   end

   int ecnt = 0;
   always @(posedge clk) ecnt++;

   int total, bad;
   int n_vs, n_hs, n_reuse, n_valid, n_wvld, n_done, n_lbrd, n_wrd;
   int e_vs, e_reuse, e_valid, e_valid8, e_done, e_lbrd, e_wrd;
   int hs_e [0:15];

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, obs, exp, ecnt);
      end
   endtask

   task automatic clear_stats();
      n_vs = 0; n_hs = 0; n_reuse = 0; n_valid = 0; n_wvld = 0; n_done = 0; n_lbrd = 0; n_wrd = 0;
      e_vs = -1; e_reuse = -1; e_valid = -1; e_valid8 = -1; e_done = -1; e_lbrd = -1; e_wrd = -1;
      for (int i = 0; i < 16; i++) hs_e[i] = -1;
   endtask

   // Observe outputs on the falling edge; ecnt is the number of rising edges so far.
   always @(negedge clk) begin
      if (bus.o_vsync) begin
         if (n_vs == 0) e_vs = ecnt;
         n_vs++;
      end
      if (bus.o_hsync) begin
         if (n_hs < 16) hs_e[n_hs] = ecnt;
         n_hs++;
      end
      if (bus.o_reuse) begin
         if (n_reuse == 0) e_reuse = ecnt;
         n_reuse++;
      end
      if (bus.o_lb_rden) begin
         if (n_lbrd == 0) e_lbrd = ecnt;
         check_eq("lb_addr", 64'(bus.o_lb_addr), 64'(lb_a(n_lbrd)));
         n_lbrd++;
      end
      if (bus.o_w_rden) begin
         if (n_wrd == 0) e_wrd = ecnt;
         check_eq("w_addr", 64'(bus.o_w_addr), 64'(n_wrd % (CHANNEL * HALF)));
         n_wrd++;
      end
      if (bus.o_valid) begin
         if (n_valid == 0) e_valid = ecnt;
         if (n_valid == 7) e_valid8 = ecnt;
         check_eq("tdata", 64'(bus.o_tdata), 64'(lb_model(lb_a(n_valid))));
         n_valid++;
      end else begin
         check_eq("tdata_idle", 64'(bus.o_tdata), 64'd0);
      end
      if (bus.o_weight_vld) begin
         check_eq("weight", 64'(bus.o_weight), 64'(w_model(3'(n_wvld % (CHANNEL * HALF)))));
         n_wvld++;
      end
      if (bus.o_done) begin
         if (n_done == 0) e_done = ecnt;
         n_done++;
      end
   end

   task automatic start_frame(output int t);
      @(negedge clk);
      bus.i_start = 1'b1;
      t = ecnt + 1;
      @(negedge clk);
      bus.i_start = 1'b0;
      check_eq("busy_after_start", 64'(bus.o_busy), 64'd1);
   endtask

   task automatic wait_edge(input int target);
      int n = 0;
      while (ecnt < target && n < 5000) begin
         @(negedge clk);
         n++;
      end
      if (ecnt != target) check_eq("edge_sync", 64'(ecnt), 64'(target));
   endtask

   task automatic wait_done();
      int n = 0;
      while (n_done == 0 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (n_done == 0) check_eq("done_timeout", 64'd0, 64'd1);
      repeat (3) @(negedge clk);
   endtask

   task automatic check_frame(input int t, input int extra);
      check_eq("n_vsync",  64'(n_vs),    64'd1);
      check_eq("n_hsync",  64'(n_hs),    64'(SIZE));
      check_eq("n_reuse",  64'(n_reuse), 64'(SIZE * CHANNEL));
      check_eq("n_valid",  64'(n_valid), 64'(SIZE * CHANNEL * SIZE));
      check_eq("n_wvld",   64'(n_wvld),  64'(SIZE * CHANNEL * HALF));
      check_eq("n_done",   64'(n_done),  64'd1);
      check_eq("done_lat", 64'(e_done - t), 64'(DONE_OFS + extra));
      check_eq("busy_end", 64'(bus.o_busy), 64'd0);
   endtask

   task automatic check_all_zero(input string tag);
      check_eq(tag, {bus.o_vsync, bus.o_hsync, bus.o_reuse, bus.o_valid, bus.o_weight_vld,
                     bus.o_lb_rden, bus.o_w_rden, bus.o_done, bus.o_busy,
                     bus.o_tdata, bus.o_lb_addr, bus.o_w_addr}, 64'd0);
      check_eq({tag, "_w"}, 64'(bus.o_weight), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int t;
      int h;
      int n;
      logic [7:0] quiet;
      total = 0;
      bad   = 0;
      rst   = 1'b1;
      bus.i_start = 1'b0;
      bus.i_ready = 1'b1;
      clear_stats();
      repeat (3) @(negedge clk);
      check_all_zero("reset_state");
      rst = 1'b0;

      // Frame 1: latency of every strobe, plus a start pulse while busy
      clear_stats();
      start_frame(t);
      wait_edge(t + 50);
      bus.i_start = 1'b1;
      @(negedge clk);
      bus.i_start = 1'b0;
      wait_done();
      check_eq("vsync_lat",  64'(e_vs - t),     64'd1);
      check_eq("hsync_lat",  64'(hs_e[0] - t),  64'd3);
      check_eq("wrden_lat",  64'(e_wrd - t),    64'd4);
      check_eq("reuse_lat",  64'(e_reuse - t),  64'd7);
      check_eq("lbrden_lat", 64'(e_lbrd - t),   64'd8);
      check_eq("valid_lat",  64'(e_valid - t),  64'd10);
      check_eq("valid8_lat", 64'(e_valid8 - t), 64'd17);
      check_eq("row_period", 64'(hs_e[1] - hs_e[0]), 64'(ROW_CYC));
      check_frame(t, 0);

      // Frame 2: ready held low for 20 sampled cycles before row 3
      clear_stats();
      start_frame(t);
      n = 0;
      while (n_hs < 3 && n < 1000) begin
         @(negedge clk);
         n++;
      end
      if (n_hs < 3) check_eq("hsync3_timeout", 64'(n_hs), 64'd3);
      h = hs_e[2];
      bus.i_ready = 1'b0;
      quiet = 8'd0;
      n = 0;
      while (ecnt < h + 92 && n < 1000) begin
         @(negedge clk);
         n++;
         if (ecnt >= h + 72 && ecnt <= h + 91)
            quiet = quiet | {bus.o_vsync, bus.o_hsync, bus.o_reuse, bus.o_valid,
                             bus.o_weight_vld, bus.o_lb_rden, bus.o_w_rden, bus.o_done};
         if (ecnt == h + 90) bus.i_ready = 1'b1;
      end
      bus.i_ready = 1'b1;
      check_eq("stall_quiet", 64'(quiet), 64'd0);
      wait_done();
      check_eq("row_period_2", 64'(hs_e[2] - hs_e[1]), 64'(ROW_CYC));
      check_eq("stall_delay",  64'(hs_e[3] - hs_e[2]), 64'(ROW_CYC + 20));
      check_frame(t, 20);

      // Frame 3: reset in the middle of row 2, pass 1 streaming
      clear_stats();
      start_frame(t);
      wait_edge(t + 169);
      check_eq("pre_rst_rden", 64'(bus.o_lb_rden), 64'd1);
      check_eq("pre_rst_rows", 64'(n_hs), 64'd3);
      rst = 1'b1;
      @(negedge clk);
      check_all_zero("mid_reset");
      rst = 1'b0;
      repeat (4) @(negedge clk);
      check_eq("idle_after_rst", 64'(bus.o_busy), 64'd0);

      // Frame 4: clean frame after reset; start held during the done cycle is ignored
      clear_stats();
      start_frame(t);
      wait_edge(t + 577);
      bus.i_start = 1'b1;
      @(negedge clk);
      bus.i_start = 1'b0;
      repeat (6) @(negedge clk);
      check_eq("vsync_lat_4", 64'(e_vs - t), 64'd1);
      check_frame(t, 0);

      // Start coincident with reset
      clear_stats();
      rst = 1'b1;
      bus.i_start = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      bus.i_start = 1'b0;
      repeat (6) @(negedge clk);
      check_eq("rst_start_vsync", 64'(n_vs), 64'd0);
      check_eq("rst_start_busy", 64'(bus.o_busy), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
